// File: rtl/logic_unit_arbiter_pkg.sv
// Shared constants for the logic-unit arbiter:
// opcodes of the bitwise unit and arbiter FSM states.
package logic_unit_arbiter_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

endpackage

// File: rtl/logic_unit_arbiter_bitlogic16.sv
// Combinational bitwise unit: AND / OR / XOR / NOT A.
// B is ignored for NOT.
module bitlogic16
  import logic_unit_arbiter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] x
);

  always_comb begin
    x = '0;
    unique case (1'b1)
      (op == OP_AND): x = a & b;
      (op == OP_OR):  x = a | b;
      (op == OP_XOR): x = a ^ b;
      (op == OP_NOT): x = ~a;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit
// between NREQ requesters, with a registered tagged result.
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [2*NREQ-1:0]        req_op,
  input  logic [WIDTH*NREQ-1:0]    req_a,
  input  logic [WIDTH*NREQ-1:0]    req_b,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WIDTH-1:0]         resp_data,
  output logic [$clog2(NREQ)-1:0]  resp_id,
  output logic                     resp_zero
);

  localparam int IDW = $clog2(NREQ);

  logic [0:0]       state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             zero_q, zero_d;

  logic             found;
  logic [IDW-1:0]   g;
  logic [IDW:0]     sum;
  logic             can_accept;
  logic             accept;
  logic [1:0]       op_g;
  logic [WIDTH-1:0] a_g, b_g, x;

  // Rotating priority search starting at ptr
  always_comb begin
    found = 1'b0;
    g     = '0;
    sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ))
        sum = sum - (IDW+1)'(NREQ);
      if (!found && req_valid[sum[IDW-1:0]]) begin
        found = 1'b1;
        g     = sum[IDW-1:0];
      end
    end
  end

  assign can_accept = (state_q == ST_IDLE) |
                      ((state_q == ST_RESP) & resp_ready);
  assign accept     = rst_n & can_accept & found;
  assign req_ready  = accept ? (NREQ'(1) << g) : '0;

  assign op_g = req_op[2*int'(g) +: 2];
  assign a_g  = req_a[WIDTH*int'(g) +: WIDTH];
  assign b_g  = req_b[WIDTH*int'(g) +: WIDTH];

  bitlogic16 #(
    .WIDTH (WIDTH)
  ) u_bitlogic (
    .op (op_g),
    .a  (a_g),
    .b  (b_g),
    .x  (x)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    id_d    = id_q;
    zero_d  = zero_q;
    if (accept) begin
      state_d = ST_RESP;
      data_d  = x;
      id_d    = g;
      zero_d  = (x == '0);
      ptr_d   = (g == IDW'(NREQ-1)) ? '0 : g + 1'b1;
    end else if (state_q == ST_RESP && resp_ready) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      data_q  <= '0;
      id_q    <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      id_q    <= id_d;
      zero_q  <= zero_d;
    end
  end

  assign resp_valid = (state_q == ST_RESP);
  assign resp_data  = data_q;
  assign resp_id    = id_q;
  assign resp_zero  = zero_q;

endmodule
